// File: rtl/snake_pkg.sv
// Shared encodings for the snake game-state block: fruit types and FSM phases.
package snake_pkg;

  localparam logic [1:0] FRUIT_NONE   = 2'b00;
  localparam logic [1:0] FRUIT_GROW   = 2'b01;
  localparam logic [1:0] FRUIT_SHRINK = 2'b10;
  localparam logic [1:0] FRUIT_LIFE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESPAWN = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

endpackage

// File: rtl/snake_state_manager_rise_detect.sv
// Single-bit rising-edge detector: rise is high while level is 1 and the
// previous clock's sample was 0.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/snake_state_manager.sv
// Game-phase FSM for the snake: owns length, lives and score, emits body
// grow/shrink pulses and handshakes fruit respawn with the spawner.
module snake_state_manager
  import snake_pkg::*;
#(
  parameter int unsigned INIT_LEN   = 3,
  parameter int unsigned MIN_LEN    = 1,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned INIT_LIVES = 3,
  parameter int unsigned MAX_LIVES  = 7,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned LIFE_W     = 3,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               game_start,
  input  logic               collision,
  input  logic [1:0]         fruit_collision_type,
  input  logic               hazard_hit,
  input  logic               respawn_ack,
  output logic               respawn_req,
  output logic               grow_pulse,
  output logic               shrink_pulse,
  output logic [LEN_W-1:0]   snake_length,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     length_d;
  logic [LIFE_W-1:0]    lives_d;
  logic [SCORE_W-1:0]   score_d;
  logic                 grow_d, shrink_d;

  logic                 collision_rise, hazard_rise, fruit_event;
  logic [LIFE_W-1:0]    lives_m1;
  logic                 last_life;
  logic [SCORE_W-1:0]   score_inc;

  rise_detect u_collision_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (collision),
    .rise    (collision_rise)
  );

  rise_detect u_hazard_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (hazard_hit),
    .rise    (hazard_rise)
  );

  assign fruit_event = collision_rise && (fruit_collision_type != FRUIT_NONE);
  assign lives_m1    = (lives == '0) ? '0 : lives - LIFE_W'(1);
  assign last_life   = (lives_m1 == '0);
  assign score_inc   = (score == '1) ? score : score + SCORE_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    length_d = snake_length;
    lives_d  = lives;
    score_d  = score;
    grow_d   = 1'b0;
    shrink_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (game_start) begin
          state_d  = ST_RUN;
          length_d = LEN_W'(INIT_LEN);
          lives_d  = LIFE_W'(INIT_LIVES);
          score_d  = '0;
        end
      end

      ST_RUN: begin
        // A hazard on the same edge as a fruit wins; the fruit stays uneaten.
        if (hazard_rise) begin
          length_d = LEN_W'(INIT_LEN);
          lives_d  = lives_m1;
          if (last_life) state_d = ST_OVER;
        end else if (fruit_event) begin
          state_d = ST_RESPAWN;
          case (fruit_collision_type)
            FRUIT_GROW: begin
              if (snake_length < LEN_W'(MAX_LEN)) begin
                length_d = snake_length + LEN_W'(1);
                grow_d   = 1'b1;
              end
              score_d = score_inc;
            end
            FRUIT_SHRINK: begin
              if (snake_length > LEN_W'(MIN_LEN)) begin
                length_d = snake_length - LEN_W'(1);
                shrink_d = 1'b1;
              end else begin
                lives_d = lives_m1;
                if (last_life) state_d = ST_OVER;
              end
            end
            FRUIT_LIFE: begin
              if (lives < LIFE_W'(MAX_LIVES)) lives_d = lives + LIFE_W'(1);
              score_d = score_inc;
            end
            default: ;
          endcase
        end
      end

      ST_RESPAWN: begin
        if (respawn_ack) state_d = ST_RUN;
        // A hazard costs a life but keeps the pending respawn alive.
        if (hazard_rise) begin
          length_d = LEN_W'(INIT_LEN);
          lives_d  = lives_m1;
          if (last_life) state_d = ST_OVER;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      snake_length <= LEN_W'(INIT_LEN);
      lives        <= LIFE_W'(INIT_LIVES);
      score        <= '0;
      grow_pulse   <= 1'b0;
      shrink_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      snake_length <= length_d;
      lives        <= lives_d;
      score        <= score_d;
      grow_pulse   <= grow_d;
      shrink_pulse <= shrink_d;
    end
  end

  assign respawn_req = (state_q == ST_RESPAWN);
  assign playing     = (state_q == ST_RUN) || (state_q == ST_RESPAWN);
  assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_state_manager.sv
// Self-checking bench for snake_state_manager: a vector table plus modelled
// saturation and reset sequences, checked through an expected-value queue.
module tb_snake_state_manager;

  typedef struct packed {
    logic       start;
    logic       coll;
    logic [1:0] typ;
    logic       haz;
    logic       ack;
  } stim_t;

  typedef struct packed {
    logic        req;
    logic        grow;
    logic        shrink;
    logic [5:0]  len;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        playing;
    logic        over;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        game_start, collision, hazard_hit, respawn_ack;
  logic [1:0]  fruit_collision_type;
  logic        respawn_req, grow_pulse, shrink_pulse, playing, game_over;
  logic [5:0]  snake_length;
  logic [2:0]  lives;
  logic [15:0] score;

  int n_vec  = 0;
  int n_miss = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  snake_state_manager dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .game_start           (game_start),
    .collision            (collision),
    .fruit_collision_type (fruit_collision_type),
    .hazard_hit           (hazard_hit),
    .respawn_ack          (respawn_ack),
    .respawn_req          (respawn_req),
    .grow_pulse           (grow_pulse),
    .shrink_pulse         (shrink_pulse),
    .snake_length         (snake_length),
    .lives                (lives),
    .score                (score),
    .playing              (playing),
    .game_over            (game_over)
  );

  function automatic exp_t sample();
    return '{req: respawn_req, grow: grow_pulse, shrink: shrink_pulse,
             len: snake_length, lives: lives, score: score,
             playing: playing, over: game_over};
  endfunction

  function automatic vec_t mk(input logic st, input logic co, input logic [1:0] ty,
                              input logic hz, input logic ak,
                              input logic rq, input logic gr, input logic sh,
                              input int ln, input int lv, input int sc,
                              input logic pl, input logic ov);
    vec_t v;
    v.s = '{start: st, coll: co, typ: ty, haz: hz, ack: ak};
    v.e = '{req: rq, grow: gr, shrink: sh, len: 6'(ln), lives: 3'(lv),
            score: 16'(sc), playing: pl, over: ov};
    return v;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got req=%0b grow=%0b shrink=%0b len=%0d lives=%0d score=%0d playing=%0b over=%0b, want req=%0b grow=%0b shrink=%0b len=%0d lives=%0d score=%0d playing=%0b over=%0b",
               name, got.req, got.grow, got.shrink, got.len, got.lives, got.score,
               got.playing, got.over, want.req, want.grow, want.shrink, want.len,
               want.lives, want.score, want.playing, want.over);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input stim_t s, input exp_t e, input string name);
    exp_t want;
    @(negedge clk);
    game_start           = s.start;
    collision            = s.coll;
    fruit_collision_type = s.typ;
    hazard_hit           = s.haz;
    respawn_ack          = s.ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check(name, sample(), want);
  endtask

  initial begin
    int    m_len, m_lives, m_score;
    logic  grew;
    stim_t s;
    exp_t  e;

    reset_n = 1'b0;
    game_start = 1'b0; collision = 1'b0; fruit_collision_type = 2'b00;
    hazard_hit = 1'b0; respawn_ack = 1'b0;
    #12;
    check("reset_state", sample(), mk(0,0,0,0,0, 0,0,0,3,3,0,0,0).e);
    @(negedge clk);
    reset_n = 1'b1;

    //            st co ty   hz ak  rq gr sh len lv sc pl ov
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 3, 3, 0, 0, 0)); // 0 idle
    tbl.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 3, 3, 0, 1, 0)); // 1 start
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  1, 1, 0, 4, 3, 1, 1, 0)); // 2 grow edge
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  1, 0, 0, 4, 3, 1, 1, 0)); // 3 held
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  1, 0, 0, 4, 3, 1, 1, 0)); // 4 held
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  1, 0, 0, 4, 3, 1, 1, 0)); // 5 held
    tbl.push_back(mk(0, 1, 2'd1, 0, 1,  0, 0, 0, 4, 3, 1, 1, 0)); // 6 ack
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  0, 0, 0, 4, 3, 1, 1, 0)); // 7 level in RUN
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 4, 3, 1, 1, 0)); // 8
    tbl.push_back(mk(0, 1, 2'd0, 0, 0,  0, 0, 0, 4, 3, 1, 1, 0)); // 9 type none
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 4, 3, 1, 1, 0)); // 10
    tbl.push_back(mk(0, 1, 2'd3, 0, 0,  1, 0, 0, 4, 4, 2, 1, 0)); // 11 extra life
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  1, 0, 0, 4, 4, 2, 1, 0)); // 12 awaiting ack
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  1, 0, 0, 4, 4, 2, 1, 0)); // 13 fruit in RESPAWN
    tbl.push_back(mk(0, 0, 2'd0, 0, 1,  0, 0, 0, 4, 4, 2, 1, 0)); // 14 ack
    tbl.push_back(mk(0, 0, 2'd0, 1, 0,  0, 0, 0, 3, 3, 2, 1, 0)); // 15 hazard in RUN
    tbl.push_back(mk(0, 0, 2'd0, 0, 1,  0, 0, 0, 3, 3, 2, 1, 0)); // 16 stray ack
    tbl.push_back(mk(0, 1, 2'd2, 0, 0,  1, 0, 1, 2, 3, 2, 1, 0)); // 17 shrink
    tbl.push_back(mk(0, 0, 2'd0, 0, 1,  0, 0, 0, 2, 3, 2, 1, 0)); // 18
    tbl.push_back(mk(0, 1, 2'd2, 0, 0,  1, 0, 1, 1, 3, 2, 1, 0)); // 19 shrink to 1
    tbl.push_back(mk(0, 0, 2'd0, 0, 1,  0, 0, 0, 1, 3, 2, 1, 0)); // 20
    tbl.push_back(mk(0, 1, 2'd2, 0, 0,  1, 0, 0, 1, 2, 2, 1, 0)); // 21 shrink at MIN
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  1, 0, 0, 1, 2, 2, 1, 0)); // 22
    tbl.push_back(mk(0, 0, 2'd0, 1, 0,  1, 0, 0, 3, 1, 2, 1, 0)); // 23 hazard in RESPAWN
    tbl.push_back(mk(0, 0, 2'd0, 0, 1,  0, 0, 0, 3, 1, 2, 1, 0)); // 24 ack
    tbl.push_back(mk(0, 1, 2'd1, 1, 0,  0, 0, 0, 3, 0, 2, 0, 1)); // 25 last life
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 3, 0, 2, 0, 1)); // 26
    tbl.push_back(mk(0, 1, 2'd1, 0, 0,  0, 0, 0, 3, 0, 2, 0, 1)); // 27 fruit in OVER
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 3, 0, 2, 0, 1)); // 28
    tbl.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 3, 3, 0, 1, 0)); // 29 restart
    tbl.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 3, 3, 0, 1, 0)); // 30 start in RUN
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 3, 3, 0, 1, 0)); // 31
    tbl.push_back(mk(0, 1, 2'd1, 1, 0,  0, 0, 0, 3, 2, 0, 1, 0)); // 32 hazard+fruit
    tbl.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 3, 2, 0, 1, 0)); // 33

    foreach (tbl[i]) apply(tbl[i].s, tbl[i].e, $sformatf("table[%0d]", i));

    // Length saturation: grow well past the ceiling, acking each respawn.
    m_len = 3; m_lives = 2; m_score = 0;
    for (int i = 0; i < 31; i++) begin
      grew = (m_len < 32);
      if (grew) m_len++;
      m_score++;
      s = '{start: 0, coll: 1, typ: 2'd1, haz: 0, ack: 0};
      e = mk(0,0,0,0,0, 1, grew, 0, m_len, m_lives, m_score, 1, 0).e;
      apply(s, e, $sformatf("grow_sat[%0d]", i));
      s = '{start: 0, coll: 0, typ: 2'd0, haz: 0, ack: 1};
      e = mk(0,0,0,0,0, 0, 0, 0, m_len, m_lives, m_score, 1, 0).e;
      apply(s, e, $sformatf("grow_ack[%0d]", i));
    end

    // Lives saturation at the ceiling.
    for (int i = 0; i < 6; i++) begin
      if (m_lives < 7) m_lives++;
      m_score++;
      s = '{start: 0, coll: 1, typ: 2'd3, haz: 0, ack: 0};
      e = mk(0,0,0,0,0, 1, 0, 0, m_len, m_lives, m_score, 1, 0).e;
      apply(s, e, $sformatf("life_sat[%0d]", i));
      s = '{start: 0, coll: 0, typ: 2'd0, haz: 0, ack: 1};
      e = mk(0,0,0,0,0, 0, 0, 0, m_len, m_lives, m_score, 1, 0).e;
      apply(s, e, $sformatf("life_ack[%0d]", i));
    end

    // Enter RESPAWN, then pull reset mid-cycle: handshake aborts immediately.
    m_score++;
    s = '{start: 0, coll: 1, typ: 2'd1, haz: 0, ack: 0};
    apply(s, mk(0,0,0,0,0, 1, 0, 0, m_len, m_lives, m_score, 1, 0).e, "pre_reset_respawn");
    @(negedge clk);
    collision = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("reset_in_respawn", sample(), mk(0,0,0,0,0, 0,0,0,3,3,0,0,0).e);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0,0,0,0,0, 0,0,0,3,3,0,0,0).s, mk(0,0,0,0,0, 0,0,0,3,3,0,0,0).e, "idle_after_reset");
    apply(mk(1,0,0,0,0, 0,0,0,3,3,0,1,0).s, mk(1,0,0,0,0, 0,0,0,3,3,0,1,0).e, "start_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
